// File: rtl/stage_mem_pkg.sv
// Shared defaults and FSM encoding for the stage memory controller.
package stage_mem_pkg;

  localparam int DATA_W = 72;
  localparam int ADDR_W = 10;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with combinational grants; a tie goes to
// whichever requester was not granted most recently.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_upd,
  input  logic req_rd,
  output logic gnt_upd,
  output logic gnt_rd
);

  logic upd_pref;  // 1: the update side wins the next tie

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      upd_pref <= 1'b1;
    end else if (gnt_upd) begin
      upd_pref <= 1'b0;
    end else if (gnt_rd) begin
      upd_pref <= 1'b1;
    end
  end

  assign gnt_upd = en && req_upd && (!req_rd || upd_pref);
  assign gnt_rd  = en && req_rd && (!req_upd || !upd_pref);

endmodule

// File: rtl/stage_mem_ctrl.sv
// Single-port BRAM controller: arbitrates table updates against readbacks and
// runs a full-memory zero sweep on request.
module stage_mem_ctrl
  import stage_mem_pkg::*;
#(
  parameter int DATA = DATA_W,
  parameter int ADDR = ADDR_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            upd_valid,
  output logic            upd_ready,
  input  logic [ADDR-1:0] upd_addr,
  input  logic [DATA-1:0] upd_data,
  input  logic            rd_valid,
  output logic            rd_ready,
  input  logic [ADDR-1:0] rd_addr,
  output logic            rsp_valid,
  output logic [DATA-1:0] rsp_data,
  input  logic            clr_start,
  output logic            clr_busy,
  output logic            clr_done,
  output logic            mem_wr,
  output logic [ADDR-1:0] mem_addr,
  output logic [DATA-1:0] mem_din,
  input  logic [DATA-1:0] mem_dout
);

  state_t        state_q, state_d;
  logic [ADDR:0] clr_cnt_q, clr_cnt_d;
  logic          arb_en, clr_wr, clr_last;
  logic          rd_pend;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .en      (arb_en),
    .req_upd (upd_valid),
    .req_rd  (rd_valid),
    .gnt_upd (upd_ready),
    .gnt_rd  (rd_ready)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // NOTE: every signal written here gets a default first, otherwise a path
  // that skips an assignment would infer a latch.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    arb_en    = 1'b0;
    clr_wr    = 1'b0;
    clr_last  = 1'b0;
    case (state_q)
      IDLE: begin
        arb_en = !clr_start;
        if (clr_start) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      CLEAR: begin
        // The extra counter bit flags that all 2**ADDR words have been issued.
        if (clr_cnt_q[ADDR]) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
          clr_last  = 1'b1;
        end else begin
          clr_wr    = 1'b1;
          clr_cnt_d = clr_cnt_q + {{ADDR{1'b0}}, 1'b1};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the BRAM contents themselves are never reset; zeroing them is the
  // explicit job of the clear sweep, which reset may abort part-way.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      rd_pend   <= 1'b0;
      rsp_valid <= 1'b0;
      clr_done  <= 1'b0;
    end else begin
      mem_wr    <= 1'b0;
      rd_pend   <= rd_valid && rd_ready;
      rsp_valid <= rd_pend;
      clr_done  <= clr_last;
      if (clr_wr) begin
        mem_wr   <= 1'b1;
        mem_addr <= clr_cnt_q[ADDR-1:0];
        mem_din  <= '0;
      end else if (upd_valid && upd_ready) begin
        mem_wr   <= 1'b1;
        mem_addr <= upd_addr;
        mem_din  <= upd_data;
      end else if (rd_valid && rd_ready) begin
        mem_addr <= rd_addr;
      end
    end
  end

  assign rsp_data = mem_dout;
  assign clr_busy = (state_q == CLEAR);

endmodule

// File: tb/tb_stage_mem_ctrl.sv
// Scoreboard bench for stage_mem_ctrl with a behavioural BRAM and memory model.
module tb_stage_mem_ctrl;

  localparam int DATA = 72;
  localparam int ADDR = 4;
  localparam int D    = 1 << ADDR;

  typedef logic [127:0] w_t;
  typedef struct {
    logic [DATA-1:0] data;
    bit              known;
    int              cyc;
  } exp_t;
  typedef enum bit {G_UPD, G_RD} who_t;

  logic            clk, rst;
  logic            upd_valid, upd_ready, rd_valid, rd_ready;
  logic [ADDR-1:0] upd_addr, rd_addr, mem_addr;
  logic [DATA-1:0] upd_data, rsp_data, mem_din, mem_dout;
  logic            rsp_valid, clr_start, clr_busy, clr_done, mem_wr;

  int checks = 0;
  int errors = 0;

  stage_mem_ctrl #(.DATA(DATA), .ADDR(ADDR)) dut (
    .clk       (clk),
    .rst       (rst),
    .upd_valid (upd_valid),
    .upd_ready (upd_ready),
    .upd_addr  (upd_addr),
    .upd_data  (upd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_addr   (rd_addr),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first BRAM with one cycle of read latency.
  logic [DATA-1:0] bram [D];
  always @(posedge clk) begin
    mem_dout <= bram[mem_addr];
    if (mem_wr) bram[mem_addr] <= mem_din;
  end

  task automatic check(input string name, input w_t act, input w_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA-1:0] rand_word();
    logic [95:0] w;
    w = {$urandom(), $urandom(), $urandom()};
    return w[DATA-1:0];
  endfunction

  // ---------------- reference model + monitor ----------------
  logic [DATA-1:0] ref_mem [D];
  bit              known [D];
  exp_t            exp_q [$];
  who_t            last_grant = G_RD;
  int              clear_left = 0;
  bit              done_pend = 0;
  int              cyc = 0;
  bit              rst_seen = 1'b1;
  bit              prev_upd = 0, prev_rd = 0;
  logic [ADDR-1:0] prev_ua = '0, prev_ra = '0;
  logic [DATA-1:0] prev_ud = '0;

  always @(posedge clk) rst_seen <= rst;

  always @(negedge clk) begin : mon
    exp_t e;
    bit   idle, en, ex_u, ex_r, hs_u, hs_r;
    cyc++;
    if (rst_seen) begin
      exp_q.delete();
      if (clear_left > 0) known = '{default: 1'b0};
      clear_left = 0;
      done_pend  = 0;
      last_grant = G_RD;
      prev_upd   = 0;
      prev_rd    = 0;
    end

    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("rsp_valid_unexpected", w_t'(rsp_valid), w_t'(0));
      end else begin
        e = exp_q.pop_front();
        check("rsp_latency", w_t'(cyc - e.cyc), w_t'(2));
        if (e.known) check("rsp_data", w_t'(rsp_data), w_t'(e.data));
      end
    end

    if (clear_left >= 1 && clear_left <= D) begin
      check("clr_mem_wr", w_t'(mem_wr), w_t'(1));
      check("clr_mem_addr", w_t'(mem_addr), w_t'(D - clear_left));
      check("clr_mem_din", w_t'(mem_din), w_t'(0));
    end else if (prev_upd) begin
      check("upd_mem_wr", w_t'(mem_wr), w_t'(1));
      check("upd_mem_addr", w_t'(mem_addr), w_t'(prev_ua));
      check("upd_mem_din", w_t'(mem_din), w_t'(prev_ud));
    end else if (prev_rd) begin
      check("rd_mem_wr", w_t'(mem_wr), w_t'(0));
      check("rd_mem_addr", w_t'(mem_addr), w_t'(prev_ra));
    end else begin
      check("idle_mem_wr", w_t'(mem_wr), w_t'(0));
    end

    idle = (clear_left == 0);
    check("clr_busy", w_t'(clr_busy), w_t'(!idle));
    check("clr_done", w_t'(clr_done), w_t'(done_pend));
    done_pend = 0;

    en   = idle && !clr_start;
    ex_u = 0;
    ex_r = 0;
    if (en) begin
      if (upd_valid && rd_valid) begin
        if (last_grant == G_RD) ex_u = 1; else ex_r = 1;
      end else begin
        ex_u = upd_valid;
        ex_r = rd_valid;
      end
    end
    check("upd_ready", w_t'(upd_ready), w_t'(ex_u));
    check("rd_ready", w_t'(rd_ready), w_t'(ex_r));

    hs_u = upd_valid && upd_ready;
    hs_r = rd_valid && rd_ready;
    if (hs_u) begin
      ref_mem[upd_addr] = upd_data;
      known[upd_addr]   = 1;
      last_grant        = G_UPD;
    end
    if (hs_r) begin
      e.data  = ref_mem[rd_addr];
      e.known = known[rd_addr];
      e.cyc   = cyc;
      exp_q.push_back(e);
      last_grant = G_RD;
    end
    prev_upd = hs_u;
    prev_ua  = upd_addr;
    prev_ud  = upd_data;
    prev_rd  = hs_r;
    prev_ra  = rd_addr;

    // A clear keeps the controller busy for D+1 cycles; clr_done follows.
    if (clear_left > 0) begin
      clear_left--;
      if (clear_left == 0) done_pend = 1;
    end else if (clr_start) begin
      clear_left = D + 1;
      for (int i = 0; i < D; i++) begin
        ref_mem[i] = '0;
        known[i]   = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; upd_valid = 0; rd_valid = 0; clr_start = 0;
    tick();
    rst = 0;
  endtask

  task automatic send_upd(input logic [ADDR-1:0] a, input logic [DATA-1:0] d);
    bit ok = 0;
    upd_valid = 1; upd_addr = a; upd_data = d;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk);
      ok = upd_ready;
      tick();
    end
    upd_valid = 0;
    check("upd_handshake_timeout", w_t'(ok), w_t'(1));
  endtask

  task automatic send_rd(input logic [ADDR-1:0] a);
    bit ok = 0;
    rd_valid = 1; rd_addr = a;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk);
      ok = rd_ready;
      tick();
    end
    rd_valid = 0;
    check("rd_handshake_timeout", w_t'(ok), w_t'(1));
  endtask

  task automatic wait_done(input bit pulse_mid);
    bit done = 0;
    for (int i = 0; i < D + 8 && !done; i++) begin
      @(negedge clk);
      done = clr_done;
      tick();
      clr_start = pulse_mid && (i == 4);
    end
    clr_start = 0;
    check("clr_done_timeout", w_t'(done), w_t'(1));
  endtask

  initial begin : stim
    bit hit;
    rst = 1; upd_valid = 0; rd_valid = 0; clr_start = 0;
    upd_addr = '0; rd_addr = '0; upd_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_wr", w_t'(mem_wr), w_t'(0));
    check("rst_mem_addr", w_t'(mem_addr), w_t'(0));
    check("rst_mem_din", w_t'(mem_din), w_t'(0));
    check("rst_rsp_valid", w_t'(rsp_valid), w_t'(0));
    check("rst_clr_busy", w_t'(clr_busy), w_t'(0));
    check("rst_clr_done", w_t'(clr_done), w_t'(0));
    tick();
    rst = 0;

    // Update then immediate readback of the same address.
    send_upd(ADDR'(5), DATA'(8'hAB));
    send_rd(ADDR'(5));
    repeat (4) tick();

    // Both requesters held: grants alternate starting with the update side.
    do_reset();
    upd_valid = 1; upd_addr = ADDR'(6); upd_data = rand_word();
    rd_valid = 1; rd_addr = ADDR'(6);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("alt_upd_ready", w_t'(upd_ready), w_t'(i % 2 == 0));
      check("alt_rd_ready", w_t'(rd_ready), w_t'(i % 2 == 1));
      tick();
    end
    upd_valid = 0; rd_valid = 0;
    repeat (3) tick();

    // Back-to-back readbacks of 1, 2, 3.
    for (int i = 1; i <= 3; i++) send_upd(ADDR'(i), rand_word());
    rd_valid = 1;
    for (int i = 1; i <= 3; i++) begin
      rd_addr = ADDR'(i);
      @(negedge clk);
      check("b2b_rd_ready", w_t'(rd_ready), w_t'(1));
      tick();
    end
    rd_valid = 0;
    repeat (3) tick();

    // Clear right after an accepted readback, with requests pending throughout.
    send_rd(ADDR'(2));
    clr_start = 1; upd_valid = 1; upd_addr = ADDR'(9); upd_data = rand_word();
    rd_valid = 1; rd_addr = ADDR'(4);
    tick();
    clr_start = 0;
    wait_done(1'b1);
    upd_valid = 0; rd_valid = 0;
    for (int i = 0; i < 4; i++) send_rd(ADDR'($urandom_range(0, D - 1)));
    repeat (3) tick();

    // Reset while the sweep is writing address 7.
    clr_start = 1;
    tick();
    clr_start = 0;
    hit = 0;
    for (int i = 0; i < D + 8 && !hit; i++) begin
      @(negedge clk);
      if (mem_wr && mem_addr == ADDR'(7)) hit = 1;
      else tick();
    end
    check("abort_addr7_seen", w_t'(hit), w_t'(1));
    #1 rst = 1;
    tick();
    rst = 0;
    repeat (D + 4) tick();
    send_upd(ADDR'(3), rand_word());
    send_rd(ADDR'(3));
    repeat (3) tick();

    // Full clear, then randomized traffic with sporadic clear requests.
    clr_start = 1;
    tick();
    clr_start = 0;
    wait_done(1'b0);
    for (int c = 0; c < 400; c++) begin
      upd_valid = ($urandom_range(0, 2) != 0);
      upd_addr  = ADDR'($urandom_range(0, D - 1));
      upd_data  = rand_word();
      rd_valid  = ($urandom_range(0, 2) != 0);
      rd_addr   = ADDR'($urandom_range(0, D - 1));
      clr_start = ($urandom_range(0, 59) == 0);
      tick();
    end
    upd_valid = 0; rd_valid = 0; clr_start = 0;
    repeat (D + 6) tick();
    check("queue_drained", w_t'(exp_q.size()), w_t'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
